// File: rtl/arbiter_rr_4_pkg.sv
// Shared constants and helpers for the 4-way round-robin arbiter.
//   arb_state_e         : FSM encoding (IDLE = 0, OWN = 1)
//   TIMEOUT_CYC_DEFAULT : default maximum grant hold time in cycles
//   rr_pick()           : round-robin search, returns {found, index}
package arbiter_rr_4_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_e;

    localparam int unsigned TIMEOUT_CYC_DEFAULT = 256;
    localparam int unsigned HOLD_CNT_W          = 16;
    // Pointer reset to 3 so that requester 0 is searched first.
    localparam logic [1:0]  LAST_RESET          = 2'd3;

    // Search order is last+1, last+2, last+3, last+4 (mod 4). The loop runs
    // from the farthest candidate down so the nearest hit overwrites the result.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [2:0] res;
        logic [1:0] cand;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            cand = last + 2'(k);
            if (req[cand]) begin
                res = {1'b1, cand};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/arbiter_rr_4_dec.sv
// 2-to-4 one-hot decoder with enable.
//   sel_i : binary select
//   en_i  : when low the output is all-zero
//   out_o : one-hot decode of sel_i
module Decoder_2to4 (
    input  logic [1:0] sel_i,
    input  logic       en_i,
    output logic [3:0] out_o
);

    always_comb begin
        out_o = 4'b0000;
        if (en_i) begin
            out_o[sel_i] = 1'b1;
        end
    end

endmodule

// File: rtl/arbiter_rr_4.sv
// Four-requester round-robin arbiter with hold timeout.
//   clock    : sole clock, rising edge
//   reset    : synchronous, active-high
//   Req      : per-requester request, bit i = requester i
//   Done     : resource reports completion of the granted transaction
//   Grant    : one-hot grant, zero when no owner
//   GrantIdx : index of current or last owner
//   Busy     : high while a grant is held
//   Timeout  : one-cycle pulse when a grant is force-released
module arbiter_rr_4
    import arbiter_rr_4_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] Req,
    input  logic       Done,
    output logic [3:0] Grant,
    output logic [1:0] GrantIdx,
    output logic       Busy,
    output logic       Timeout
);

    localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(TIMEOUT_CYC - 1);

    arb_state_e            state_q, state_d;
    logic [1:0]            idx_q, idx_d;
    logic [1:0]            last_q, last_d;
    logic [HOLD_CNT_W-1:0] cnt_q, cnt_d;
    logic                  timeout_q, timeout_d;

    logic [2:0]            pick;
    logic                  owner_req;
    logic                  hold_expired;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        timeout_d    = 1'b0;
        pick         = rr_pick(Req, last_q);
        owner_req    = Req[idx_q];
        hold_expired = (cnt_q == HOLD_LAST);

        case (state_q)
            ST_IDLE: begin
                if (pick[2]) begin
                    state_d = ST_OWN;
                    idx_d   = pick[1:0];
                    cnt_d   = '0;
                end
            end
            ST_OWN: begin
                if (Done || !owner_req || hold_expired) begin
                    state_d   = ST_IDLE;
                    last_d    = idx_q;
                    // Done or abandon take precedence: flag only a pure timeout.
                    timeout_d = !Done && owner_req;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= 2'd0;
            last_q    <= LAST_RESET;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign Busy     = (state_q == ST_OWN);
    assign GrantIdx = idx_q;
    assign Timeout  = timeout_q;

    Decoder_2to4 u_grant_dec (
        .sel_i (idx_q),
        .en_i  (Busy),
        .out_o (Grant)
    );

endmodule

// File: tb/tb_arbiter_rr_4.sv
// Self-checking bench for arbiter_rr_4. Instance dut_a uses the default
// timeout, dut_b uses TIMEOUT_CYC = 4. Observed vector per cycle is
// {Grant, GrantIdx, Busy, Timeout}.
module tb_arbiter_rr_4;

    typedef struct packed {
        logic       rst;
        logic [3:0] req;
        logic       done;
        logic [7:0] exp;
    } step_t;

    logic       clock;
    logic       reset;
    logic [3:0] req_a, req_b;
    logic       done_a, done_b;
    logic [3:0] grant_a, grant_b;
    logic [1:0] idx_a, idx_b;
    logic       busy_a, busy_b;
    logic       to_a, to_b;
    logic [7:0] obs_a, obs_b;

    logic [7:0] exp_q[$];
    int         n_checks;
    int         n_errors;

    arbiter_rr_4 dut_a (
        .clock    (clock),
        .reset    (reset),
        .Req      (req_a),
        .Done     (done_a),
        .Grant    (grant_a),
        .GrantIdx (idx_a),
        .Busy     (busy_a),
        .Timeout  (to_a)
    );

    arbiter_rr_4 #(.TIMEOUT_CYC(4)) dut_b (
        .clock    (clock),
        .reset    (reset),
        .Req      (req_b),
        .Done     (done_b),
        .Grant    (grant_b),
        .GrantIdx (idx_b),
        .Busy     (busy_b),
        .Timeout  (to_b)
    );

    assign obs_a = {grant_a, idx_a, busy_a, to_a};
    assign obs_b = {grant_b, idx_b, busy_b, to_b};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic step_t st(input logic rst, input logic [3:0] req, input logic done,
                                 input logic [3:0] g, input logic [1:0] idx,
                                 input logic busy, input logic to);
        step_t s;
        s.rst  = rst;
        s.req  = req;
        s.done = done;
        s.exp  = {g, idx, busy, to};
        return s;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reset held with requests and Done active must leave everything idle.
    task automatic test_reset();
        step_t s[$];
        logic [7:0] e;
        s.push_back(st(1'b1, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0));
        s.push_back(st(1'b1, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0));
        s.push_back(st(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0));
        foreach (s[i]) begin
            reset = s[i].rst; req_a = s[i].req; done_a = s[i].done;
            exp_q.push_back(s[i].exp);
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (obs_a !== e) begin
                n_errors++;
                $display("FAIL reset step %0d: got %b want %b", i, obs_a, e);
            end
        end
    endtask

    // All requesting, Done one cycle after each grant: 0,1,2,3,0 with idle gaps.
    task automatic test_rotation();
        step_t s[$];
        logic [7:0] e;
        for (int k = 0; k < 5; k++) begin
            s.push_back(st(1'b0, 4'b1111, 1'b0, 4'(1 << (k % 4)), 2'(k % 4), 1'b1, 1'b0));
            s.push_back(st(1'b0, 4'b1111, 1'b1, 4'b0000, 2'(k % 4), 1'b0, 1'b0));
        end
        s.push_back(st(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0));
        foreach (s[i]) begin
            reset = s[i].rst; req_a = s[i].req; done_a = s[i].done;
            exp_q.push_back(s[i].exp);
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (obs_a !== e) begin
                n_errors++;
                $display("FAIL rotation step %0d: got %b want %b", i, obs_a, e);
            end
        end
    endtask

    // Lone request from fresh reset, Done ignored in idle, GrantIdx held in idle.
    task automatic test_single();
        step_t s[$];
        logic [7:0] e;
        s.push_back(st(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0));
        s.push_back(st(1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0));
        s.push_back(st(1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0));
        s.push_back(st(1'b0, 4'b0100, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0));
        s.push_back(st(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0));
        foreach (s[i]) begin
            reset = s[i].rst; req_a = s[i].req; done_a = s[i].done;
            exp_q.push_back(s[i].exp);
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (obs_a !== e) begin
                n_errors++;
                $display("FAIL single step %0d: got %b want %b", i, obs_a, e);
            end
        end
    endtask

    // Owner 1 ignores other requests, then abandons at cycle 5; search resumes at 2.
    task automatic test_abandon();
        step_t s[$];
        logic [7:0] e;
        s.push_back(st(1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0));
        for (int k = 0; k < 4; k++) begin
            s.push_back(st(1'b0, 4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0));
        end
        s.push_back(st(1'b0, 4'b1101, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0));
        s.push_back(st(1'b0, 4'b1101, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0));
        s.push_back(st(1'b0, 4'b1101, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0));
        s.push_back(st(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0));
        foreach (s[i]) begin
            reset = s[i].rst; req_a = s[i].req; done_a = s[i].done;
            exp_q.push_back(s[i].exp);
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (obs_a !== e) begin
                n_errors++;
                $display("FAIL abandon step %0d: got %b want %b", i, obs_a, e);
            end
        end
    endtask

    // Reset while requester 3 owns: grant drops, pointer returns to favour 0.
    task automatic test_reset_in_own();
        step_t s[$];
        logic [7:0] e;
        s.push_back(st(1'b0, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0));
        s.push_back(st(1'b1, 4'b1000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0));
        s.push_back(st(1'b0, 4'b1001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0));
        s.push_back(st(1'b0, 4'b1001, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0));
        s.push_back(st(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0));
        foreach (s[i]) begin
            reset = s[i].rst; req_a = s[i].req; done_a = s[i].done;
            exp_q.push_back(s[i].exp);
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (obs_a !== e) begin
                n_errors++;
                $display("FAIL reset_in_own step %0d: got %b want %b", i, obs_a, e);
            end
        end
    endtask

    // TIMEOUT_CYC = 4: grant held 4 cycles, forced release with pulse, regrant.
    task automatic test_timeout();
        step_t s[$];
        logic [7:0] e;
        for (int k = 0; k < 4; k++) begin
            s.push_back(st(1'b0, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0));
        end
        s.push_back(st(1'b0, 4'b0001, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1));
        s.push_back(st(1'b0, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0));
        foreach (s[i]) begin
            reset = s[i].rst; req_b = s[i].req; done_b = s[i].done;
            exp_q.push_back(s[i].exp);
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (obs_b !== e) begin
                n_errors++;
                $display("FAIL timeout step %0d: got %b want %b", i, obs_b, e);
            end
        end
    endtask

    // Done, then abandon, landing on the timeout cycle: release without pulse.
    task automatic test_done_timeout();
        step_t s[$];
        logic [7:0] e;
        for (int k = 0; k < 3; k++) begin
            s.push_back(st(1'b0, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0));
        end
        s.push_back(st(1'b0, 4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0));
        s.push_back(st(1'b0, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0));
        for (int k = 0; k < 3; k++) begin
            s.push_back(st(1'b0, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0));
        end
        s.push_back(st(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0));
        s.push_back(st(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0));
        foreach (s[i]) begin
            reset = s[i].rst; req_b = s[i].req; done_b = s[i].done;
            exp_q.push_back(s[i].exp);
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (obs_b !== e) begin
                n_errors++;
                $display("FAIL done_timeout step %0d: got %b want %b", i, obs_b, e);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset  = 1'b1;
        req_a  = 4'b0000;
        req_b  = 4'b0000;
        done_a = 1'b0;
        done_b = 1'b0;
        #2;
        test_reset();
        test_rotation();
        test_single();
        test_abandon();
        test_reset_in_own();
        test_timeout();
        test_done_timeout();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
